stage_reg: RTL

STAGE_REG -- requirements
Module: stage_reg

---
 rtl/stage_reg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stage_reg.sv
// Two-entry elastic pipeline stage: a main register drives the outputs and a
// skid register absorbs one entry of backpressure, so in_ready is purely
// registered. Optional idle-cycle counter bubble_cnt under STAGE_REG_PERF_EN.
module stage_reg #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [WIDTH-1:0]  out_data
`ifdef STAGE_REG_PERF_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [WIDTH-1:0]  main_data, skid_data;

  logic xfer_in, xfer_out;
  logic load_main_in, load_main_skid, load_skid, clear_ctrl;

  // Both handshake outputs decode the state register only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_ctrl     = 1'b0;
    if (flush) begin
      state_n    = EMPTY;
      clear_ctrl = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (xfer_in) begin
            state_n      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            load_main_in = 1'b1;
          end else if (xfer_in) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (xfer_out) begin
            state_n    = EMPTY;
            clear_ctrl = 1'b1;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state_n        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_n    = EMPTY;
          clear_ctrl = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // NOTE: the payload registers are reset too, because out_data must read 0
  // after reset; otherwise they would only need the load enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clear_ctrl) begin
        main_ctrl <= '0;   // data keeps its last value while idle
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

`ifdef STAGE_REG_PERF_EN
  logic [31:0] bubble_q;

  // Counts idle cycles, saturating; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst)                             bubble_q <= '0;
    else if (!out_valid && !(&bubble_q)) bubble_q <= bubble_q + 32'd1;
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule
